// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the RAM access arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  localparam int ADDR_W_DEF    = 12;
  localparam int DATA_W_DEF    = 8;
  localparam int MEM_DEPTH_DEF = 12;

endpackage

// File: rtl/rr_pick.sv
// Combinational priority picker: one-hot winner is the first set request
// at or after ptr, searching upward with wrap. With ptr tied to 0 this is
// plain lowest-index-wins fixed priority.
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_oh
);

  int w_best;
  int w_sel;
  int w_dist;

  // Pick the requester with the smallest wrapped distance from the pointer
  always_comb begin
    w_best = NUM_REQ;
    w_sel  = -1;
    w_dist = 0;
    gnt_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = (i + NUM_REQ - int'(ptr)) % NUM_REQ;
      if (req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_sel  = i;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_oh[i] = (w_sel == i);
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one single-port synchronous RAM between NUM_REQ requesters.
// Sequences each granted read/write onto the RAM port and returns an ack
// pulse (with read data and a range error flag). All outputs registered.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority (lowest index wins).
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic                      clock,
  input  logic                      rstn,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_wren,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      err,
  output logic [ADDR_W-1:0]         ram_address,
  output logic [DATA_W-1:0]         ram_data_in,
  output logic                      ram_wren,
  input  logic [DATA_W-1:0]         ram_data_out
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t r_state, w_state_nxt;
  logic       r_wr, w_wr_nxt;

  logic [NUM_REQ-1:0] w_gnt_nxt;
  logic [NUM_REQ-1:0] w_ack_nxt;
  logic [DATA_W-1:0]  w_rdata_nxt;
  logic               w_err_nxt;
  logic [ADDR_W-1:0]  w_addr_nxt;
  logic [DATA_W-1:0]  w_din_nxt;
  logic               w_wren_nxt;

  logic [PTR_W-1:0]   w_ptr;
  logic [NUM_REQ-1:0] w_win_oh;
  logic               w_win_wren;
  logic [ADDR_W-1:0]  w_win_addr;
  logic [DATA_W-1:0]  w_win_wdata;
  logic               w_win_oor;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req    (req),
    .ptr    (w_ptr),
    .gnt_oh (w_win_oh)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_win_idx;

  // Encode the one-hot winner to an index for the pointer update
  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win_oh[i]) w_win_idx = PTR_W'(i);
    end
  end

  // Pointer moves just past the winner at each grant, wrapping to 0
  always_ff @(posedge clock) begin
    if (!rstn) begin
      r_ptr <= '0;
    end else if ((r_state == IDLE) && (|req)) begin
      r_ptr <= (w_win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : (w_win_idx + PTR_W'(1));
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  // Mux the winner's request attributes and range-check its address
  always_comb begin
    w_win_wren  = 1'b0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win_oh[i]) begin
        w_win_wren  = req_wren[i];
        w_win_addr  = req_addr[i*ADDR_W +: ADDR_W];
        w_win_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
    w_win_oor = (w_win_addr >= ADDR_W'(MEM_DEPTH));
  end

  // Next state and next registered outputs
  always_comb begin
    w_state_nxt = r_state;
    w_wr_nxt    = r_wr;
    w_gnt_nxt   = gnt;
    w_ack_nxt   = '0;
    w_rdata_nxt = rdata;
    w_err_nxt   = err;
    w_addr_nxt  = ram_address;
    w_din_nxt   = ram_data_in;
    w_wren_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_gnt_nxt = w_win_oh;
          w_wr_nxt  = w_win_wren;
          if (w_win_oor) begin
            // Rejected address: never touch the RAM, answer immediately
            w_state_nxt = RESP;
            w_ack_nxt   = w_win_oh;
            w_err_nxt   = 1'b1;
            w_rdata_nxt = '0;
          end else begin
            w_state_nxt = ACCESS;
            w_addr_nxt  = w_win_addr;
            w_din_nxt   = w_win_wdata;
            w_wren_nxt  = w_win_wren;
          end
        end
      end
      ACCESS: begin
        if (r_wr) begin
          w_state_nxt = RESP;
          w_ack_nxt   = gnt;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        // RAM read data is valid one cycle after the address was presented
        w_state_nxt = RESP;
        w_rdata_nxt = ram_data_out;
        w_ack_nxt   = gnt;
      end
      RESP: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_err_nxt   = 1'b0;
        w_rdata_nxt = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_err_nxt   = 1'b0;
        w_rdata_nxt = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight
  always_ff @(posedge clock) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_wr        <= 1'b0;
      gnt         <= '0;
      ack         <= '0;
      rdata       <= '0;
      err         <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
      ram_wren    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr        <= w_wr_nxt;
      gnt         <= w_gnt_nxt;
      ack         <= w_ack_nxt;
      rdata       <= w_rdata_nxt;
      err         <= w_err_nxt;
      ram_address <= w_addr_nxt;
      ram_data_in <= w_din_nxt;
      ram_wren    <= w_wren_nxt;
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Self-checking bench for ram_access_arbiter with a behavioural RAM and a
// transaction-level reference model (winner choice, latency, memory image).
module tb_ram_access_arbiter;

  localparam int N     = 2;
  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int DEPTH = 12;

  logic          clock = 1'b0;
  logic          rstn;
  logic [N-1:0]  req, req_wren;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]  gnt, ack;
  logic [DW-1:0] rdata;
  logic          err;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in, ram_data_out;
  logic          ram_wren;

  logic [DW-1:0] ram     [0:(1<<AW)-1];
  logic [DW-1:0] mdl_mem [0:DEPTH-1];
  int mdl_ptr;
  int checks = 0;
  int errors = 0;

  ram_access_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .rstn(rstn), .req(req), .req_wren(req_wren),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .ack(ack),
    .rdata(rdata), .err(err), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_wren(ram_wren), .ram_data_out(ram_data_out)
  );

  always #5 clock = ~clock;

  // Single-port RAM with registered read data
  always @(posedge clock) begin
    if (ram_wren) ram[ram_address] <= ram_data_in;
    ram_data_out <= ram[ram_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] r);
    int p;
`ifdef ARB_ROUND_ROBIN_EN
    p = mdl_ptr;
`else
    p = 0;
`endif
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1;
    req_wren[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // One transaction from the current req state; called at #1 after an edge
  task automatic txn(input string tag, input logic hold, input logic [N-1:0] late_mask, input int late_cyc);
    int w, lat;
    logic oor, wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d, exp_rd;
    logic [N-1:0] oh;
    w = model_pick(req);
    if (w < 0) begin
      chk({tag, "_noreq"}, 32'(req), 32'd1);
      return;
    end
    a   = req_addr[w*AW +: AW];
    d   = req_wdata[w*DW +: DW];
    wr  = req_wren[w];
    oor = (int'(a) >= DEPTH);
    lat = oor ? 1 : (wr ? 2 : 3);
    exp_rd = (!oor && !wr) ? mdl_mem[a] : '0;
    oh = '0;
    oh[w] = 1'b1;
    mdl_ptr = (w + 1) % N;
    for (int c = 1; c <= lat; c++) begin
      @(posedge clock); #1;
      chk({tag, "_gnt"}, 32'(gnt), 32'(oh));
      chk({tag, "_ack"}, 32'(ack), (c == lat) ? 32'(oh) : 32'd0);
      chk({tag, "_wren"}, 32'(ram_wren), 32'((c == 1) && wr && !oor));
      if ((c == 1) && wr && !oor) begin
        chk({tag, "_waddr"}, 32'(ram_address), 32'(a));
        chk({tag, "_wdata"}, 32'(ram_data_in), 32'(d));
      end
      if (c == lat) begin
        chk({tag, "_err"}, 32'(err), 32'(oor));
        chk({tag, "_rdata"}, 32'(rdata), 32'(exp_rd));
      end
      if (c == late_cyc) req = req | late_mask;
    end
    if (!oor && wr) mdl_mem[a] = d;
    if (!hold) req[w] = 1'b0;
    @(posedge clock); #1;
    chk({tag, "_idle_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_idle_ack"}, 32'(ack), 32'd0);
    chk({tag, "_idle_err"}, 32'(err), 32'd0);
    chk({tag, "_idle_rdata"}, 32'(rdata), 32'd0);
    chk({tag, "_idle_wren"}, 32'(ram_wren), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
    mdl_ptr = 0;
    rstn = 1'b0;
    req = '0; req_wren = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_addr", 32'(ram_address), 0);
    chk("rst_din", 32'(ram_data_in), 0);
    chk("rst_wren", 32'(ram_wren), 0);
    rstn = 1'b1;
    @(posedge clock); #1;

    // Write then read back
    set_req(0, 1'b1, 12'd5, 8'hA5);
    txn("t1_wr", 1'b0, '0, 0);
    set_req(0, 1'b0, 12'd5, 8'h00);
    txn("t1_rd", 1'b0, '0, 0);

    // Both requesters held, reads
    set_req(0, 1'b0, 12'd5, 8'h00);
    set_req(1, 1'b0, 12'd3, 8'h00);
    for (int k = 0; k < 4; k++) txn("t2_both", 1'b1, '0, 0);
    req = '0;
    @(posedge clock); #1;

    // Range error at the first unpopulated address
    set_req(0, 1'b0, 12'd12, 8'h00);
    txn("t3_oor", 1'b0, '0, 0);
    set_req(1, 1'b1, 12'd4095, 8'h77);
    txn("t3_oor_wr", 1'b0, '0, 0);

    // Reset during ACCESS of a write
    set_req(0, 1'b1, 12'd7, 8'h3C);
    @(posedge clock); #1;
    chk("t4_access_wren", 32'(ram_wren), 1);
    rstn = 1'b0;
    @(posedge clock); #1;
    mdl_mem[7] = 8'h3C;
    mdl_ptr = 0;
    chk("t4_gnt", 32'(gnt), 0);
    chk("t4_ack", 32'(ack), 0);
    chk("t4_wren", 32'(ram_wren), 0);
    rstn = 1'b1;
    req = '0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      chk("t4_no_ack", 32'(ack), 0);
      chk("t4_no_gnt", 32'(gnt), 0);
    end

    // req1 raised while req0 waits on read data
    set_req(0, 1'b0, 12'd7, 8'h00);
    req_wren[1] = 1'b0; req_addr[AW +: AW] = 12'd5;
    txn("t5_r0", 1'b0, 2'b10, 2);
    txn("t5_r1", 1'b0, '0, 0);

    // Boundary addresses
    set_req(1, 1'b1, 12'd11, 8'hFF);
    txn("t6_wr11", 1'b0, '0, 0);
    set_req(0, 1'b0, 12'd0, 8'h00);
    txn("t6_rd0", 1'b0, '0, 0);
    set_req(0, 1'b0, 12'd11, 8'h00);
    txn("t6_rd11", 1'b0, '0, 0);

    // Randomized traffic; pending requests keep their attributes
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && ($urandom_range(0, 1) == 1))
          set_req(i, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), 8'($urandom));
      end
      if (req == '0)
        set_req(int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)),
                12'($urandom_range(0, 15)), 8'($urandom));
      txn("rnd", 1'b0, '0, 0);
    end
    while (req != '0) txn("drain", 1'b0, '0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
